// File: rtl/ctrl_mc.sv
// ctrl_mc -- multi-cycle control FSM for the SISC datapath.
//
// Sequences START0 -> START1 -> FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK.
// Branch conditions are evaluated in DECODE from stat & mm. MEM uses a
// req/ack handshake with a bounded wait: a missing ack escalates to a sticky
// fault and the terminal HALT state. The HLT opcode also enters HALT.
// All control outputs are decoded combinationally from the registered state
// and the current inputs.
//
// Ports:
//   clk       rising-edge clock
//   rst_f     asynchronous active-low reset
//   opcode    current instruction opcode (held stable by the IR)
//   mm        addressing mode / branch mask
//   stat      status flags
//   mem_ack   memory completes the transfer this cycle
//   ir_load, pc_write, pc_sel, br_sel, rf_we, alu_op[1:0], wb_sel, rd_sel,
//   mem_req, mem_we   datapath control strobes
//   halted    FSM is in HALT (sticky until reset)
//   fault     memory wait timed out (sticky until reset)
//   retired   retired-instruction count
//
// Optional feature macro: CTRL_TRACE_EN
//   defined   -> retired counts instructions leaving WRITEBACK, MEM (STR) or
//                DECODE (branch/NOOP); wraps; frozen in HALT. HALT entry is
//                reported with a simulation message.
//   undefined -> retired is tied to zero.
module ctrl_mc #(
  parameter int OPW     = 4,
  parameter int MMW     = 4,
  parameter int TMO_W   = 4,
  parameter int MEM_TMO = 12
) (
  input  logic           clk,
  input  logic           rst_f,
  input  logic [OPW-1:0] opcode,
  input  logic [MMW-1:0] mm,
  input  logic [MMW-1:0] stat,
  input  logic           mem_ack,
  output logic           ir_load,
  output logic           pc_write,
  output logic           pc_sel,
  output logic           br_sel,
  output logic           rf_we,
  output logic [1:0]     alu_op,
  output logic           wb_sel,
  output logic           rd_sel,
  output logic           mem_req,
  output logic           mem_we,
  output logic           halted,
  output logic           fault,
  output logic [15:0]    retired
);

  typedef enum logic [3:0] {
    S_START0  = 4'd0,
    S_START1  = 4'd1,
    S_FETCH   = 4'd2,
    S_DECODE  = 4'd3,
    S_EXECUTE = 4'd4,
    S_MEM     = 4'd5,
    S_WB      = 4'd6,
    S_HALT    = 4'd7
  } state_t;

  localparam logic [OPW-1:0] OP_LOD = OPW'(1);
  localparam logic [OPW-1:0] OP_STR = OPW'(2);
  localparam logic [OPW-1:0] OP_BRA = OPW'(4);
  localparam logic [OPW-1:0] OP_BRR = OPW'(5);
  localparam logic [OPW-1:0] OP_BNE = OPW'(6);
  localparam logic [OPW-1:0] OP_ALU = OPW'(8);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fault_q, fault_d;

  logic is_lod, is_str, is_brr, is_bne, is_bra, is_alu, is_hlt;
  logic br_hit, br_take;

  assign is_lod = (opcode == OP_LOD);
  assign is_str = (opcode == OP_STR);
  assign is_bra = (opcode == OP_BRA);
  assign is_brr = (opcode == OP_BRR);
  assign is_bne = (opcode == OP_BNE);
  assign is_alu = (opcode == OP_ALU);
  assign is_hlt = (opcode == OP_HLT);

  // BRA/BRR take on any masked flag set; BNE takes when none are set.
  assign br_hit  = |(stat & mm);
  assign br_take = ((is_bra | is_brr) & br_hit) | (is_bne & ~br_hit);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= S_START0;
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    fault_d  = fault_q;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    rf_we    = 1'b0;
    alu_op   = 2'b00;
    wb_sel   = 1'b0;
    rd_sel   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_START0: state_d = S_START1;
      S_START1: state_d = S_FETCH;
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (is_hlt) begin
          state_d = S_HALT;
        end else if (br_take) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = is_brr;
          state_d  = S_FETCH;
        end else if (is_lod | is_str | is_alu) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_op  = {is_lod | is_str, mm[MMW-1]};
        rd_sel  = is_str;
        tmo_d   = '0;
        state_d = (is_lod | is_str) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_str;
        rd_sel  = is_str;
        // An ack always wins, even on the cycle the wait budget runs out.
        if (mem_ack) begin
          tmo_d   = '0;
          state_d = is_str ? S_FETCH : S_WB;
        end else if (tmo_q == TMO_LAST) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        wb_sel  = is_lod;
        state_d = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_START0;
    endcase
  end

  assign fault = fault_q;

`ifdef CTRL_TRACE_EN
  logic [15:0] ret_q, ret_d;
  logic        retire;

  // An instruction retires when control returns toward FETCH from its last
  // active state; HALT never produces such a transition, freezing the count.
  assign retire = (state_q == S_WB) |
                  ((state_q == S_MEM) & mem_ack & is_str) |
                  ((state_q == S_DECODE) & (state_d == S_FETCH));
  assign ret_d  = retire ? ret_q + 16'd1 : ret_q;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) ret_q <= 16'h0;
    else        ret_q <= ret_d;
  end

  always_ff @(posedge clk) begin
    if (rst_f && (state_q != S_HALT) && (state_d == S_HALT))
      $display("ctrl_mc: entering HALT from state %0d", state_q);
  end

  assign retired = ret_q;
`else
  assign retired = 16'h0;
`endif

endmodule

// File: tb/tb_ctrl_mc.sv
module tb_ctrl_mc;

  typedef struct packed {
    logic       ir_load;
    logic       pc_write;
    logic       pc_sel;
    logic       br_sel;
    logic       rf_we;
    logic [1:0] alu_op;
    logic       wb_sel;
    logic       rd_sel;
    logic       mem_req;
    logic       mem_we;
    logic       halted;
    logic       fault;
  } outs_t;

  localparam int MEM_TMO = 12;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [3:0]  opcode, mm, stat;
  logic        mem_ack;
  logic        ir_load, pc_write, pc_sel, br_sel, rf_we, wb_sel, rd_sel;
  logic        mem_req, mem_we, halted, fault;
  logic [1:0]  alu_op;
  logic [15:0] retired;
  outs_t       obs;
  outs_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;

  ctrl_mc #(.OPW(4), .MMW(4), .TMO_W(4), .MEM_TMO(MEM_TMO)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .mem_ack(mem_ack), .ir_load(ir_load), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .rf_we(rf_we), .alu_op(alu_op),
    .wb_sel(wb_sel), .rd_sel(rd_sel), .mem_req(mem_req), .mem_we(mem_we),
    .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  assign obs = {ir_load, pc_write, pc_sel, br_sel, rf_we, alu_op, wb_sel,
                rd_sel, mem_req, mem_we, halted, fault};

  // Reference: per-cycle control vector for one instruction starting at FETCH.
  // w = wait cycles before ack in MEM; w >= MEM_TMO means the ack never comes.
  task automatic build_exp(input logic [3:0] op, input logic [3:0] a_mm,
                           input logic [3:0] a_st, input int w);
    outs_t v;
    bit    hit, take;
    exp_q.delete();
    v = '0; v.ir_load = 1; v.pc_write = 1; exp_q.push_back(v);
    hit = ((a_st & a_mm) != 4'd0);
    case (op)
      4'd15: begin
        v = '0; exp_q.push_back(v);
        v.halted = 1; repeat (3) exp_q.push_back(v);
      end
      4'd4, 4'd5, 4'd6: begin
        take = (op == 4'd6) ? !hit : hit;
        v = '0;
        if (take) begin v.pc_write = 1; v.pc_sel = 1; v.br_sel = (op == 4'd5); end
        exp_q.push_back(v);
      end
      4'd1, 4'd2, 4'd8: begin
        v = '0; exp_q.push_back(v);
        v.alu_op = {op != 4'd8, a_mm[3]}; v.rd_sel = (op == 4'd2);
        exp_q.push_back(v);
        if (op != 4'd8) begin
          v = '0; v.mem_req = 1; v.mem_we = (op == 4'd2); v.rd_sel = (op == 4'd2);
          if (w >= MEM_TMO) begin
            repeat (MEM_TMO) exp_q.push_back(v);
            v = '0; v.halted = 1; v.fault = 1;
            repeat (3) exp_q.push_back(v);
            return;
          end
          repeat (w + 1) exp_q.push_back(v);
        end
        if (op != 4'd2) begin
          v = '0; v.rf_we = 1; v.wb_sel = (op == 4'd1); exp_q.push_back(v);
        end
      end
      default: begin v = '0; exp_q.push_back(v); end
    endcase
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [3:0] a_mm,
                           input logic [3:0] a_st, input int w, input string name);
    bit is_mem;
    is_mem = (op == 4'd1) || (op == 4'd2);
    build_exp(op, a_mm, a_st, w);
    for (int i = 0; i < exp_q.size(); i++) begin
      opcode = op; mm = a_mm; stat = a_st;
      if (is_mem && i >= 3) mem_ack = (i == 3 + w);
      else mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s op=%0d cyc=%0d got=%b want=%b", name, op, i, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_to_fetch();
    rst_f = 1'b0; mem_ack = 1'b0;
    #3 rst_f = 1'b1;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_f = 1'b0; opcode = 0; mm = 0; stat = 0; mem_ack = 0;
    #12;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_hold got=%b want=0", obs); end
    if (fault !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b want=00", halted, fault); end
    checks++;
    @(posedge clk); #3 rst_f = 1'b1; #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL start0 got=%b want=0", obs); end
    @(posedge clk); #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL start1 got=%b want=0", obs); end
    @(posedge clk); #1;
    checks++;
    if (ir_load !== 1'b1 || pc_write !== 1'b1) begin
      errors++; $display("FAIL fetch_after_reset got=%b want ir_load,pc_write=1", obs);
    end
    // Reset asserted in the middle of EXECUTE of a LOD.
    opcode = 4'd1; mm = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (alu_op !== 2'b10) begin errors++; $display("FAIL exec_lod alu_op got=%b want=10", alu_op); end
    #2 rst_f = 1'b0; #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_mid_exec got=%b want=0", obs); end
    @(posedge clk); #1;
    reset_to_fetch();
    checks++;
    if (ir_load !== 1'b1) begin errors++; $display("FAIL refetch got=%b want ir_load=1", obs); end
    // Reset in MEM drops mem_req without waiting for an edge.
    opcode = 4'd2;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL mem_str got=%b want req,we=1", obs); end
    #2 rst_f = 1'b0; #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mid_mem got=%b%b want=00", mem_req, mem_we); end
    @(posedge clk); #1;
    reset_to_fetch();
  endtask

  task automatic test_alu_imm();
    run_instr(4'd8, 4'd8, 4'($urandom_range(0, 15)), 0, "alu_imm");
    run_instr(4'd8, 4'd0, 4'd0, 0, "alu_reg");
  endtask

  task automatic test_lod_wait();
    run_instr(4'd1, 4'd0, 4'd0, 3, "lod_wait3");
    run_instr(4'd1, 4'd8, 4'd0, 0, "lod_wait0");
    run_instr(4'd2, 4'd0, 4'd0, 2, "str_wait2");
  endtask

  task automatic test_branch();
    run_instr(4'd6, 4'b0001, 4'b0000, 0, "bne_taken");
    run_instr(4'd6, 4'b0001, 4'b0001, 0, "bne_not_taken");
    run_instr(4'd4, 4'b0110, 4'b0100, 0, "bra_taken");
    run_instr(4'd5, 4'b0110, 4'b1001, 0, "brr_not_taken");
    run_instr(4'd5, 4'b1000, 4'b1000, 0, "brr_taken");
  endtask

  task automatic test_str_timeout();
    run_instr(4'd2, 4'd0, 4'd0, MEM_TMO - 1, "str_ack_at_limit");
    run_instr(4'd2, 4'd0, 4'd0, MEM_TMO + 5, "str_timeout");
    reset_to_fetch();
    checks++;
    if (fault !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL fault_cleared got=%b%b want=00", halted, fault);
    end
  endtask

  task automatic test_hlt();
    outs_t want;
    run_instr(4'd15, 4'd0, 4'd0, 0, "hlt");
    want = '0; want.halted = 1;
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom); mm = 4'($urandom); stat = 4'($urandom);
      mem_ack = 1'($urandom);
      @(negedge clk);
      checks++;
      if (obs !== want) begin errors++; $display("FAIL hlt_hold cyc=%0d got=%b want=%b", i, obs, want); end
      @(posedge clk); #1;
    end
    reset_to_fetch();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                            4'd8, 4'd9, 4'd12, 4'd14};
    for (int n = 0; n < 60; n++) begin
      run_instr(ops[$urandom_range(0, 11)], 4'($urandom), 4'($urandom),
                int'($urandom_range(0, 5)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_alu_imm();
    test_lod_wait();
    test_branch();
    test_back_to_back();
    test_str_timeout();
    test_hlt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
